// File: rtl/mc_control_pkg.sv
// Shared opcode/funct constants, state encodings and control-word layout for the
// multicycle controller. MC_CONTROL_ADDI_EN adds the ADDIEX/ADDIWB states.
package mc_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  localparam logic [2:0] SRCB_B       = 3'b000;
  localparam logic [2:0] SRCB_FOUR    = 3'b001;
  localparam logic [2:0] SRCB_IMM     = 3'b010;
  localparam logic [2:0] SRCB_IMM_SH2 = 3'b011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // TRAP keeps a fixed code so the encoding does not shift with the ADDI option.
  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_RTYPEEX = 4'd6,
    ST_RTYPEWB = 4'd7,
    ST_BEQEX   = 4'd8,
    ST_BNEEX   = 4'd9,
    ST_JEX     = 4'd10,
    ST_JREX    = 4'd11,
`ifdef MC_CONTROL_ADDI_EN
    ST_ADDIEX  = 4'd12,
    ST_ADDIWB  = 4'd13,
`endif
    ST_TRAP    = 4'd14
  } state_t;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcen;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] pcsource;
    logic [2:0] alusrcb;
    logic [1:0] aluop;
    logic       err;
  } ctrl_t;

  // States that own a memory access and may stall on memready.
  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational state-to-control-word decode for mc_control. ADDI states are
// decoded only when MC_CONTROL_ADDI_EN is defined.
module mc_outdec
  import mc_control_pkg::*;
(
  input  state_t state,
  input  logic   memready,
  input  logic   zero,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        // IR load and PC+4 commit only when the fetch actually completes.
        ctrl.irwrite = memready;
        ctrl.pcen    = memready;
      end
      ST_DECODE: begin
        ctrl.alusrcb = SRCB_IMM_SH2;
      end
      ST_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      ST_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      ST_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      ST_RTYPEWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      ST_BEQEX: begin
        ctrl.alusrca  = 1'b1;
        ctrl.aluop    = ALUOP_SUB;
        ctrl.pcsource = PCSRC_ALUOUT;
        ctrl.pcen     = zero;
      end
      ST_BNEEX: begin
        ctrl.alusrca  = 1'b1;
        ctrl.aluop    = ALUOP_SUB;
        ctrl.pcsource = PCSRC_ALUOUT;
        ctrl.pcen     = ~zero;
      end
      ST_JEX: begin
        ctrl.pcsource = PCSRC_JUMP;
        ctrl.pcen     = 1'b1;
      end
      ST_JREX: begin
        ctrl.pcsource = PCSRC_REG;
        ctrl.pcen     = 1'b1;
      end
`ifdef MC_CONTROL_ADDI_EN
      ST_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      ST_ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
`endif
      ST_TRAP: begin
        ctrl.err = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS-style controller: state register, next-state logic and memory
// wait watchdog. Define MC_CONTROL_ADDI_EN to execute addi instead of trapping.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       memready_i,
  output logic       memread_o,
  output logic       memwrite_o,
  output logic       iord_o,
  output logic       irwrite_o,
  output logic       pcen_o,
  output logic       regwrite_o,
  output logic       regdst_o,
  output logic       memtoreg_o,
  output logic       alusrca_o,
  output logic [1:0] pcsource_o,
  output logic [2:0] alusrcb_o,
  output logic [1:0] aluop_o,
  output logic       err_o,
  output logic [3:0] state_o
);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic [CNT_W-1:0] wait_cnt_next;
  logic             mem_wait;
  logic             timeout;
  ctrl_t            ctrl;
  ctrl_t            ctrl_gated;

  assign mem_wait = is_mem_state(state_reg) && !memready_i;

  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout
      assign timeout = mem_wait && (wait_cnt_reg == CNT_W'(MEM_TIMEOUT));
    end else begin : g_no_timeout
      assign timeout = 1'b0;
    end
  endgenerate

  // Non-memory states and completed accesses clear the counter, so every access
  // starts counting from zero on entry.
  always_comb begin
    wait_cnt_next = '0;
    if (mem_wait) begin
      wait_cnt_next = (&wait_cnt_reg) ? wait_cnt_reg : wait_cnt_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH:   if (memready_i) state_next = ST_DECODE;
      ST_DECODE: begin
        case (op_i)
          OP_LW, OP_SW: state_next = ST_MEMADR;
          OP_RTYPE:     state_next = ST_RTYPEEX;
          OP_BEQ:       state_next = ST_BEQEX;
          OP_BNE:       state_next = ST_BNEEX;
          OP_J:         state_next = ST_JEX;
`ifdef MC_CONTROL_ADDI_EN
          OP_ADDI:      state_next = ST_ADDIEX;
`endif
          default:      state_next = ST_TRAP;
        endcase
      end
      ST_MEMADR:  state_next = (op_i == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:   if (memready_i) state_next = ST_MEMWB;
      ST_MEMWB:   state_next = ST_FETCH;
      ST_MEMWR:   if (memready_i) state_next = ST_FETCH;
      ST_RTYPEEX: state_next = (funct_i == FUNCT_JR) ? ST_JREX : ST_RTYPEWB;
      ST_RTYPEWB: state_next = ST_FETCH;
      ST_BEQEX:   state_next = ST_FETCH;
      ST_BNEEX:   state_next = ST_FETCH;
      ST_JEX:     state_next = ST_FETCH;
      ST_JREX:    state_next = ST_FETCH;
`ifdef MC_CONTROL_ADDI_EN
      ST_ADDIEX:  state_next = ST_ADDIWB;
      ST_ADDIWB:  state_next = ST_FETCH;
`endif
      ST_TRAP:    state_next = ST_TRAP;
      default:    state_next = ST_TRAP;
    endcase
    // A stalled access that has used up its budget traps; memready in the same
    // cycle means mem_wait is low, so completion takes precedence.
    if (timeout) state_next = ST_TRAP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_FETCH;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  mc_outdec u_outdec (
    .state    (state_reg),
    .memready (memready_i),
    .zero     (zero_i),
    .ctrl     (ctrl)
  );

  // Strobes are forced quiet for the whole reset interval, not just after the edge.
  assign ctrl_gated = rst ? '0 : ctrl;

  assign memread_o  = ctrl_gated.memread;
  assign memwrite_o = ctrl_gated.memwrite;
  assign iord_o     = ctrl_gated.iord;
  assign irwrite_o  = ctrl_gated.irwrite;
  assign pcen_o     = ctrl_gated.pcen;
  assign regwrite_o = ctrl_gated.regwrite;
  assign regdst_o   = ctrl_gated.regdst;
  assign memtoreg_o = ctrl_gated.memtoreg;
  assign alusrca_o  = ctrl_gated.alusrca;
  assign pcsource_o = ctrl_gated.pcsource;
  assign alusrcb_o  = ctrl_gated.alusrcb;
  assign aluop_o    = ctrl_gated.aluop;
  assign err_o      = ctrl_gated.err;
  assign state_o    = state_reg;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: a default-timeout instance for the main flows
// and a MEM_TIMEOUT=2 instance for the watchdog, one held in reset while the other runs.
module tb_mc_control;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3;
  localparam logic [3:0] S_MEMWB = 4'd4,  S_MEMWR  = 4'd5,  S_RTEX   = 4'd6,  S_RTWB  = 4'd7;
  localparam logic [3:0] S_BEQ   = 4'd8,  S_BNE    = 4'd9,  S_JEX    = 4'd10, S_JREX  = 4'd11;
  localparam logic [3:0] S_ADDIEX = 4'd12, S_ADDIWB = 4'd13, S_TRAP  = 4'd14;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, J = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_JR = 6'b001000;

  // Word layout: memread memwrite iord irwrite pcen regwrite regdst memtoreg alusrca
  //              pcsource[1:0] alusrcb[2:0] aluop[1:0] err
  localparam logic [16:0] W_ZERO     = 17'b0_0_0_0_0_0_0_0_0_00_000_00_0;
  localparam logic [16:0] W_FETCH_WT = 17'b1_0_0_0_0_0_0_0_0_00_001_00_0;
  localparam logic [16:0] W_FETCH_GO = 17'b1_0_0_1_1_0_0_0_0_00_001_00_0;
  localparam logic [16:0] W_DECODE   = 17'b0_0_0_0_0_0_0_0_0_00_011_00_0;
  localparam logic [16:0] W_MEMADR   = 17'b0_0_0_0_0_0_0_0_1_00_010_00_0;
  localparam logic [16:0] W_MEMRD    = 17'b1_0_1_0_0_0_0_0_0_00_000_00_0;
  localparam logic [16:0] W_MEMWB    = 17'b0_0_0_0_0_1_0_1_0_00_000_00_0;
  localparam logic [16:0] W_MEMWR    = 17'b0_1_1_0_0_0_0_0_0_00_000_00_0;
  localparam logic [16:0] W_RTEX     = 17'b0_0_0_0_0_0_0_0_1_00_000_10_0;
  localparam logic [16:0] W_RTWB     = 17'b0_0_0_0_0_1_1_0_0_00_000_00_0;
  localparam logic [16:0] W_BR_NT    = 17'b0_0_0_0_0_0_0_0_1_01_000_01_0;
  localparam logic [16:0] W_BR_T     = 17'b0_0_0_0_1_0_0_0_1_01_000_01_0;
  localparam logic [16:0] W_JEX      = 17'b0_0_0_0_1_0_0_0_0_10_000_00_0;
  localparam logic [16:0] W_JREX     = 17'b0_0_0_0_1_0_0_0_0_11_000_00_0;
  localparam logic [16:0] W_ADDIWB   = 17'b0_0_0_0_0_1_0_0_0_00_000_00_0;
  localparam logic [16:0] W_TRAP     = 17'b0_0_0_0_0_0_0_0_0_00_000_00_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, rst_b = 1'b1;
  logic [5:0] op = '0, funct = '0;
  logic       zero = 1'b0, memready = 1'b0;

  logic a_memread, a_memwrite, a_iord, a_irwrite, a_pcen, a_regwrite, a_regdst, a_memtoreg, a_alusrca, a_err;
  logic b_memread, b_memwrite, b_iord, b_irwrite, b_pcen, b_regwrite, b_regdst, b_memtoreg, b_alusrca, b_err;
  logic [1:0] a_pcsource, b_pcsource, a_aluop, b_aluop;
  logic [2:0] a_alusrcb, b_alusrcb;
  logic [3:0] a_state, b_state;

  mc_control dut_a (
    .clk(clk), .rst(rst_a), .op_i(op), .funct_i(funct), .zero_i(zero), .memready_i(memready),
    .memread_o(a_memread), .memwrite_o(a_memwrite), .iord_o(a_iord), .irwrite_o(a_irwrite),
    .pcen_o(a_pcen), .regwrite_o(a_regwrite), .regdst_o(a_regdst), .memtoreg_o(a_memtoreg),
    .alusrca_o(a_alusrca), .pcsource_o(a_pcsource), .alusrcb_o(a_alusrcb), .aluop_o(a_aluop),
    .err_o(a_err), .state_o(a_state)
  );

  mc_control #(.MEM_TIMEOUT(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .op_i(op), .funct_i(funct), .zero_i(zero), .memready_i(memready),
    .memread_o(b_memread), .memwrite_o(b_memwrite), .iord_o(b_iord), .irwrite_o(b_irwrite),
    .pcen_o(b_pcen), .regwrite_o(b_regwrite), .regdst_o(b_regdst), .memtoreg_o(b_memtoreg),
    .alusrca_o(b_alusrca), .pcsource_o(b_pcsource), .alusrcb_o(b_alusrcb), .aluop_o(b_aluop),
    .err_o(b_err), .state_o(b_state)
  );

  logic [16:0] wa, wb;
  assign wa = {a_memread, a_memwrite, a_iord, a_irwrite, a_pcen, a_regwrite, a_regdst, a_memtoreg,
               a_alusrca, a_pcsource, a_alusrcb, a_aluop, a_err};
  assign wb = {b_memread, b_memwrite, b_iord, b_irwrite, b_pcen, b_regwrite, b_regdst, b_memtoreg,
               b_alusrca, b_pcsource, b_alusrcb, b_aluop, b_err};

  typedef struct {
    bit          sel;
    logic [3:0]  st;
    logic [16:0] w;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // One cycle of stimulus; the selected instance gets r, the other stays in reset.
  task automatic step(input bit sel, input bit r, input logic [5:0] o, input logic [5:0] f,
                      input bit z, input bit rdy, input logic [3:0] st, input logic [16:0] w,
                      input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_a    = (sel == 1'b0) ? r : 1'b1;
    rst_b    = (sel == 1'b1) ? r : 1'b1;
    op       = o;
    funct    = f;
    zero     = z;
    memready = rdy;
    e.sel  = sel;
    e.st   = st;
    e.w    = w;
    e.name = nm;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [3:0]  act_st;
    logic [16:0] act_w;
    if (sb.size() > 0) begin
      e      = sb.pop_front();
      act_st = e.sel ? b_state : a_state;
      act_w  = e.sel ? wb : wa;
      total++;
      if (act_st !== e.st) begin
        bad++;
        $display("FAIL %s state: got %0d required %0d", e.name, act_st, e.st);
      end
      total++;
      if (act_w !== e.w) begin
        bad++;
        $display("FAIL %s ctrl: got %b required %b", e.name, act_w, e.w);
      end
      $display("txn %-12s dut=%0d state=%0d ctrl=%b", e.name, e.sel, act_st, act_w);
    end
  end

  initial begin
    // reset state
    step(0, 1, LW, F_ADD, 0, 1, S_FETCH, W_ZERO, "rst_hold");
    // lw with memory always ready
    step(0, 0, LW, F_ADD, 0, 1, S_FETCH,  W_FETCH_GO, "lw_fetch");
    step(0, 0, LW, F_ADD, 0, 1, S_DECODE, W_DECODE,   "lw_decode");
    step(0, 0, LW, F_ADD, 0, 1, S_MEMADR, W_MEMADR,   "lw_memadr");
    step(0, 0, LW, F_ADD, 0, 1, S_MEMRD,  W_MEMRD,    "lw_memrd");
    step(0, 0, LW, F_ADD, 0, 1, S_MEMWB,  W_MEMWB,    "lw_memwb");
    // fetch stall for three cycles, then sw with a one-cycle write stall
    for (int i = 0; i < 3; i++) step(0, 0, SW, F_ADD, 0, 0, S_FETCH, W_FETCH_WT, "fetch_wait");
    step(0, 0, SW, F_ADD, 0, 1, S_FETCH,  W_FETCH_GO, "fetch_done");
    step(0, 0, SW, F_ADD, 0, 1, S_DECODE, W_DECODE,   "sw_decode");
    step(0, 0, SW, F_ADD, 0, 1, S_MEMADR, W_MEMADR,   "sw_memadr");
    step(0, 0, SW, F_ADD, 0, 0, S_MEMWR,  W_MEMWR,    "sw_wait");
    step(0, 0, SW, F_ADD, 0, 1, S_MEMWR,  W_MEMWR,    "sw_done");
    // R-type add
    step(0, 0, RT, F_ADD, 0, 1, S_FETCH,  W_FETCH_GO, "rt_fetch");
    step(0, 0, RT, F_ADD, 0, 1, S_DECODE, W_DECODE,   "rt_decode");
    step(0, 0, RT, F_ADD, 0, 1, S_RTEX,   W_RTEX,     "rt_ex");
    step(0, 0, RT, F_ADD, 0, 1, S_RTWB,   W_RTWB,     "rt_wb");
    // branches with both zero flag values
    step(0, 0, BEQ, F_ADD, 0, 1, S_FETCH,  W_FETCH_GO, "beq0_fetch");
    step(0, 0, BEQ, F_ADD, 0, 1, S_DECODE, W_DECODE,   "beq0_decode");
    step(0, 0, BEQ, F_ADD, 0, 1, S_BEQ,    W_BR_NT,    "beq_z0");
    step(0, 0, BEQ, F_ADD, 1, 1, S_FETCH,  W_FETCH_GO, "beq1_fetch");
    step(0, 0, BEQ, F_ADD, 1, 1, S_DECODE, W_DECODE,   "beq1_decode");
    step(0, 0, BEQ, F_ADD, 1, 1, S_BEQ,    W_BR_T,     "beq_z1");
    step(0, 0, BNE, F_ADD, 0, 1, S_FETCH,  W_FETCH_GO, "bne0_fetch");
    step(0, 0, BNE, F_ADD, 0, 1, S_DECODE, W_DECODE,   "bne0_decode");
    step(0, 0, BNE, F_ADD, 0, 1, S_BNE,    W_BR_T,     "bne_z0");
    step(0, 0, BNE, F_ADD, 1, 1, S_FETCH,  W_FETCH_GO, "bne1_fetch");
    step(0, 0, BNE, F_ADD, 1, 1, S_DECODE, W_DECODE,   "bne1_decode");
    step(0, 0, BNE, F_ADD, 1, 1, S_BNE,    W_BR_NT,    "bne_z1");
    // jumps
    step(0, 0, J,  F_ADD, 0, 1, S_FETCH,  W_FETCH_GO, "j_fetch");
    step(0, 0, J,  F_ADD, 0, 1, S_DECODE, W_DECODE,   "j_decode");
    step(0, 0, J,  F_ADD, 0, 1, S_JEX,    W_JEX,      "j_ex");
    step(0, 0, RT, F_JR,  0, 1, S_FETCH,  W_FETCH_GO, "jr_fetch");
    step(0, 0, RT, F_JR,  0, 1, S_DECODE, W_DECODE,   "jr_decode");
    step(0, 0, RT, F_JR,  0, 1, S_RTEX,   W_RTEX,     "jr_rtex");
    step(0, 0, RT, F_JR,  0, 1, S_JREX,   W_JREX,     "jr_ex");
    // illegal opcode traps and holds regardless of memready
    step(0, 0, BAD, F_ADD, 0, 1, S_FETCH,  W_FETCH_GO, "bad_fetch");
    step(0, 0, BAD, F_ADD, 0, 1, S_DECODE, W_DECODE,   "bad_decode");
    step(0, 0, BAD, F_ADD, 0, 1, S_TRAP,   W_TRAP,     "bad_trap");
    step(0, 0, LW,  F_ADD, 0, 0, S_TRAP,   W_TRAP,     "trap_hold");
    step(0, 1, LW,  F_ADD, 0, 1, S_TRAP,   W_ZERO,     "trap_rst");
    step(0, 0, SW,  F_ADD, 0, 1, S_FETCH,  W_FETCH_GO, "post_trap");
    // reset in the middle of a stalled store
    step(0, 0, SW, F_ADD, 0, 1, S_DECODE, W_DECODE,   "swr_decode");
    step(0, 0, SW, F_ADD, 0, 0, S_MEMADR, W_MEMADR,   "swr_memadr");
    step(0, 0, SW, F_ADD, 0, 0, S_MEMWR,  W_MEMWR,    "swr_wait");
    step(0, 1, SW, F_ADD, 0, 0, S_MEMWR,  W_ZERO,     "swr_rst1");
    step(0, 1, SW, F_ADD, 0, 0, S_FETCH,  W_ZERO,     "swr_rst2");
    step(0, 0, ADDI, F_ADD, 0, 0, S_FETCH,  W_FETCH_WT, "swr_resume");
    step(0, 0, ADDI, F_ADD, 0, 1, S_FETCH,  W_FETCH_GO, "addi_fetch");
    step(0, 0, ADDI, F_ADD, 0, 1, S_DECODE, W_DECODE,   "addi_decode");
`ifdef MC_CONTROL_ADDI_EN
    step(0, 0, ADDI, F_ADD, 0, 1, S_ADDIEX, W_MEMADR,   "addi_ex");
    step(0, 0, ADDI, F_ADD, 0, 1, S_ADDIWB, W_ADDIWB,   "addi_wb");
    step(0, 0, ADDI, F_ADD, 0, 1, S_FETCH,  W_FETCH_GO, "addi_next");
`else
    step(0, 0, ADDI, F_ADD, 0, 1, S_TRAP,   W_TRAP,     "addi_trap");
`endif
    // watchdog instance: read stalls past MEM_TIMEOUT=2
    step(1, 1, LW, F_ADD, 0, 1, S_FETCH,  W_ZERO,     "to_rst");
    step(1, 0, LW, F_ADD, 0, 1, S_FETCH,  W_FETCH_GO, "to_fetch");
    step(1, 0, LW, F_ADD, 0, 1, S_DECODE, W_DECODE,   "to_decode");
    step(1, 0, LW, F_ADD, 0, 0, S_MEMADR, W_MEMADR,   "to_memadr");
    for (int i = 0; i < 3; i++) step(1, 0, LW, F_ADD, 0, 0, S_MEMRD, W_MEMRD, "to_wait");
    step(1, 0, LW, F_ADD, 0, 1, S_TRAP,   W_TRAP,     "to_trap");
    step(1, 0, LW, F_ADD, 0, 1, S_TRAP,   W_TRAP,     "to_hold");
    step(1, 1, LW, F_ADD, 0, 1, S_TRAP,   W_ZERO,     "to_rst2");
    // completion on the last allowed wait cycle beats the timeout
    step(1, 0, LW, F_ADD, 0, 1, S_FETCH,  W_FETCH_GO, "edge_fetch");
    step(1, 0, LW, F_ADD, 0, 1, S_DECODE, W_DECODE,   "edge_decode");
    step(1, 0, LW, F_ADD, 0, 0, S_MEMADR, W_MEMADR,   "edge_memadr");
    step(1, 0, LW, F_ADD, 0, 0, S_MEMRD,  W_MEMRD,    "edge_wait1");
    step(1, 0, LW, F_ADD, 0, 0, S_MEMRD,  W_MEMRD,    "edge_wait2");
    step(1, 0, LW, F_ADD, 0, 1, S_MEMRD,  W_MEMRD,    "edge_ready");
    step(1, 0, LW, F_ADD, 0, 1, S_MEMWB,  W_MEMWB,    "edge_memwb");
    step(1, 0, LW, F_ADD, 0, 0, S_FETCH,  W_FETCH_WT, "edge_fetch2");

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: max consecutive memready_i-low wait cycles per memory access before trap; 0 disables the timeout.
REQ-002 Parameter CNT_W, default 4: width of the wait counter; SHALL satisfy 2**CNT_W > MEM_TIMEOUT.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 op_i  in  6  instruction opcode [31:26]; funct_i  in  6  instruction funct [5:0].
REQ-006 zero_i  in  1  ALU zero flag; memready_i  in  1  memory completes current access this cycle.
REQ-007 memread_o, memwrite_o, iord_o, irwrite_o, pcen_o, regwrite_o, regdst_o, memtoreg_o, alusrca_o  out  1  datapath strobes/selects.
REQ-008 pcsource_o  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 register (jr).
REQ-009 alusrcb_o  out  3  000 B, 001 const 4, 010 sign-ext imm, 011 sign-ext imm<<2; aluop_o  out  2  00 add, 01 sub, 10 funct.
REQ-010 err_o  out  1  trap indication; state_o  out  4  current state encoding.

Function
REQ-011 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, BNEEX, JEX, JREX, ADDIEX, ADDIWB, TRAP.
REQ-012 Every output not listed for a state SHALL be 0.
REQ-013 FETCH: memread=1, alusrcb=001; irwrite=1 and pcen=1 only in the cycle memready_i=1, then go to DECODE; otherwise hold FETCH.
REQ-014 DECODE: alusrcb=011; next by op_i: 100011/101011 MEMADR, 000000 RTYPEEX, 000100 BEQEX, 000101 BNEEX, 000010 JEX, 001000 ADDIEX; any other op TRAP.
REQ-015 MEMADR: alusrca=1, alusrcb=010; go to MEMRD for lw, MEMWR for sw.
REQ-016 MEMRD: memread=1, iord=1; on memready_i go to MEMWB. MEMWB: regwrite=1, memtoreg=1; go to FETCH.
REQ-017 MEMWR: memwrite=1, iord=1; on memready_i go to FETCH.
REQ-018 RTYPEEX: alusrca=1, aluop=10; go to JREX if funct_i=001000, else RTYPEWB. RTYPEWB: regwrite=1, regdst=1; go to FETCH.
REQ-019 BEQEX: alusrca=1, aluop=01, pcsource=01, pcen=zero_i. BNEEX: same, pcen=~zero_i. Both go to FETCH.
REQ-020 JEX: pcsource=10, pcen=1. JREX: pcsource=11, pcen=1. Both go to FETCH.
REQ-021 ADDIEX: alusrca=1, alusrcb=010; go to ADDIWB. ADDIWB: regwrite=1; go to FETCH.
REQ-022 Memory strobe SHALL stay asserted, with address select unchanged, until memready_i is sampled high.
REQ-023 Wait counter: clears on entering FETCH/MEMRD/MEMWR and on memready_i=1; increments each wait cycle; saturates at its maximum.
REQ-024 With MEM_TIMEOUT>0, a wait cycle with counter=MEM_TIMEOUT SHALL go to TRAP next cycle; memready_i=1 in that same cycle wins (normal completion).
REQ-025 TRAP: err_o=1, all strobes 0, state held until rst.

Reset
REQ-026 rst=1 at a clock edge SHALL force FETCH, clear the wait counter and err_o, and take priority over any transition, including mid-access.
REQ-027 While rst=1, all strobe outputs SHALL be 0; FETCH strobes resume the cycle after rst deasserts.

Configuration
REQ-028 Macro MC_CONTROL_ADDI_EN: defined, op 001000 executes via ADDIEX/ADDIWB; undefined, ADDIEX/ADDIWB SHALL not exist and op 001000 SHALL go to TRAP.

Structure
REQ-029 Opcode/funct constants, state encodings, and the pcsource/alusrcb/aluop encodings SHALL live in the shared defines package.
REQ-030 State-to-control-word decode SHALL be a combinational sub-module mc_outdec; mc_control holds state register, next-state logic and wait counter.

Verification
REQ-031 lw, memready_i always 1 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; 5 cycles; regwrite=memtoreg=1 in cycle 5.
REQ-032 FETCH with memready_i low 3 cycles -> memread=1 for 4 cycles; irwrite/pcen pulse once, in cycle 4.
REQ-033 MEM_TIMEOUT=2, memready_i held 0 in MEMRD -> TRAP on 4th cycle after entry; err_o=1; state held until rst.
REQ-034 beq with zero_i=0 -> pcen=0; bne with zero_i=0 -> pcen=1, pcsource=01.
REQ-035 R-type funct 001000 -> JREX, pcsource=11, pcen=1, no regwrite; op 111111 -> TRAP after DECODE.
REQ-036 rst asserted during MEMWR wait -> memwrite=0 during rst; FETCH with memread=1 the cycle after rst deasserts; addi -> TRAP without MC_CONTROL_ADDI_EN.
